// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: two cascaded half-adder stages plus a carry flop, one bit per clock.
// Operands load on start, sum/cout are registered and announced by a one-cycle done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state;
  logic [WIDTH-1:0] ra, rb, rs, rs_next;
  logic             c;
  logic [CntW-1:0]  cnt;

  logic ha1_s, ha1_c, ha2_s, ha2_c, carry;

  // Stage 1 adds the operand bits, stage 2 folds in the running carry.
  always_comb begin
    ha1_s = ra[0] ^ rb[0];
    ha1_c = ra[0] & rb[0];
    ha2_s = ha1_s ^ c;
    ha2_c = ha1_s & c;
    carry = ha1_c | ha2_c;
  end

  generate
    if (WIDTH > 1) begin : g_wide
      assign rs_next = {ha2_s, rs[WIDTH-1:1]};
    end else begin : g_one
      assign rs_next = ha2_s;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= StIdle;
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (state)
        // The done cycle may already accept the next request, giving back-to-back operation.
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            rs    <= '0;
            c     <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= StRun;
          end else begin
            state <= StIdle;
          end
        end
        StRun: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          rs  <= rs_next;
          c   <= carry;
          cnt <= cnt + 1'b1;
          if (cnt == CntW'(WIDTH - 1)) begin
            sum   <= rs_next;
            cout  <= carry;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= StDone;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH=8: latency, busy span, sum hold,
// mid-run reset, back-to-back start and arithmetic results.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation from start edge E0 through the cycle after done.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input string tag);
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    int           k, busy_n, hold_bad;
    logic [W:0]   exp;
    prev_sum  = sum;
    prev_cout = cout;
    exp       = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
    a = ta; b = tb_; cin = tc; start = 1'b1;
    tick();
    start    = 1'b0;
    busy_n   = busy ? 1 : 0;
    hold_bad = 0;
    k        = 0;
    while (!done && k < 40) begin
      if (sum !== prev_sum || cout !== prev_cout) hold_bad++;
      tick();
      k++;
      if (!done && busy) busy_n++;
    end
    check({tag, " latency"}, 64'(k), 64'(W));
    check({tag, " busy_cycles"}, 64'(busy_n), 64'(W));
    check({tag, " hold"}, 64'(hold_bad), 64'd0);
    check({tag, " result"}, 64'({cout, sum}), 64'(exp));
    tick();
    check({tag, " done_pulse"}, 64'({done, busy}), 64'd0);
  endtask

  initial begin
    int k, dones;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_state", 64'({busy, done, cout, sum}), 64'd0);

    run_op(8'h5A, 8'h3C, 1'b0, "basic");
    check("basic sum", 64'(sum), 64'h96);
    run_op(8'hFF, 8'h01, 1'b0, "ovf");
    check("ovf sum", 64'({cout, sum}), 64'h100);
    run_op(8'hFF, 8'hFF, 1'b1, "max");
    check("max sum", 64'({cout, sum}), 64'h1FF);

    // Start held high; operand change mid-run must not disturb the running add.
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    tick();
    tick(); tick(); tick();
    a = 8'h77; b = 8'h11;
    k = 3;
    while (!done && k < 40) begin tick(); k++; end
    check("held latency", 64'(k), 64'(W));
    check("held sum", 64'({cout, sum}), 64'h003);
    tick();
    check("held reaccept", 64'({busy, done}), 64'b10);
    start = 1'b0;
    k = 0;
    while (!done && k < 40) begin tick(); k++; end
    check("held second", 64'({cout, sum}), 64'h088);
    tick();

    // Reset in the 4th run cycle discards the operation.
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid", 64'({busy, done, cout, sum}), 64'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (done) dones++; end
    check("rst_no_done", 64'(dones), 64'd0);
    run_op(8'h12, 8'h34, 1'b1, "after_rst");
    check("after_rst sum", 64'(sum), 64'h47);

    run_op(8'h10, 8'h20, 1'b0, "hold_a");
    check("hold_a sum", 64'(sum), 64'h30);
    run_op(8'h01, 8'h01, 1'b0, "hold_b");
    check("hold_b sum", 64'(sum), 64'h02);

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      run_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
